// File: rtl/image_pkg.sv
// Shared image-processing types and helpers for the edge-detection pipeline.
// Pixel, window and gradient types plus small arithmetic helpers used by the Sobel stage.
package image_pkg;

    localparam int PIXEL_W     = 8;
    localparam int KERNEL_SIZE = 3;
    localparam int SUM_W       = 10;   // a + 2b + c of three pixels, max 1020
    localparam int GRAD_W      = 11;   // signed difference of two sums
    localparam int ABS_W       = 10;
    localparam int MAG_W       = 11;   // |Gx| + |Gy|, max 2040

    typedef logic [PIXEL_W-1:0]       pixel_t;
    typedef pixel_t                   window_t [KERNEL_SIZE][KERNEL_SIZE];
    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic [SUM_W-1:0]         sum_t;
    typedef logic [ABS_W-1:0]         abs_t;
    typedef logic [MAG_W-1:0]         mag_t;

    // Sideband bits travelling alongside each pipeline token.
    typedef struct packed {
        logic valid;
        logic border;
        logic last;
    } side_t;

    function automatic sum_t weighted_sum(input pixel_t a, input pixel_t b, input pixel_t c);
        return sum_t'(a) + {1'b0, b, 1'b0} + sum_t'(c);
    endfunction

    function automatic grad_t grad_diff(input sum_t pos, input sum_t neg);
        return $signed({1'b0, pos}) - $signed({1'b0, neg});
    endfunction

    // Magnitude of a gradient in -1020..+1020 always fits 10 unsigned bits.
    function automatic abs_t grad_abs(input grad_t g);
        grad_t n;
        n = -g;
        return g[GRAD_W-1] ? abs_t'(n) : abs_t'(g);
    endfunction

    function automatic pixel_t saturate(input mag_t m);
        return (m > mag_t'(255)) ? pixel_t'(255) : m[PIXEL_W-1:0];
    endfunction

endpackage

// File: rtl/sobel_stage_if.sv
// Window-in / gradient-out bundle of the Sobel stage.
// The producer side (window stage or bench) uses master; sobel_stage uses slave.
interface sobel_stage_if;
    import image_pkg::*;

    logic    in_valid;
    window_t window;
    pixel_t  threshold;
    logic    out_valid;
    pixel_t  pix_out;
    logic    edge_flag;   // "edge" is a reserved word
    logic    border;
    logic    last;

    modport master (
        output in_valid, window, threshold,
        input  out_valid, pix_out, edge_flag, border, last
    );

    modport slave (
        input  in_valid, window, threshold,
        output out_valid, pix_out, edge_flag, border, last
    );

endinterface

// File: rtl/raster_counter.sv
// Raster row/column tracker for a streaming frame; flags border and end-of-frame
// for the current (pre-increment) position. Advances only when advance is high.
module raster_counter #(
    parameter int ROW_WIDTH = 640,
    parameter int NUM_ROWS  = 480
) (
    input  logic clk,
    input  logic reset_n,
    input  logic advance,
    output logic border,
    output logic last
);

    localparam int COL_W = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
    localparam int ROW_W = (NUM_ROWS  > 1) ? $clog2(NUM_ROWS)  : 1;
    localparam logic [COL_W-1:0] COL_MAX   = COL_W'(ROW_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(2);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (advance) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // The 3x3 window is only complete once two rows and two columns have been seen.
    assign border = (row_q < ROW_FIRST) || (col_q < COL_FIRST);
    assign last   = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/sobel_stage.sv
// Three-stage Sobel gradient magnitude: signed Gx/Gy, absolute values, then
// saturated |Gx|+|Gy| with border masking and threshold compare.
module sobel_stage
    import image_pkg::*;
#(
    parameter int ROW_WIDTH = 640,
    parameter int NUM_ROWS  = 480
) (
    input logic          clk,
    input logic          reset_n,
    sobel_stage_if.slave bus
);

    logic pos_border;
    logic pos_last;

    raster_counter #(
        .ROW_WIDTH (ROW_WIDTH),
        .NUM_ROWS  (NUM_ROWS)
    ) u_raster (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (bus.in_valid),
        .border  (pos_border),
        .last    (pos_last)
    );

    // Stage 1: signed gradients from the four weighted column/row sums.
    sum_t  gx_pos, gx_neg, gy_pos, gy_neg;
    grad_t gx_q, gx_d, gy_q, gy_d;
    side_t side1_q, side1_d;

    assign gx_pos = weighted_sum(bus.window[0][2], bus.window[1][2], bus.window[2][2]);
    assign gx_neg = weighted_sum(bus.window[0][0], bus.window[1][0], bus.window[2][0]);
    assign gy_pos = weighted_sum(bus.window[2][0], bus.window[2][1], bus.window[2][2]);
    assign gy_neg = weighted_sum(bus.window[0][0], bus.window[0][1], bus.window[0][2]);

    always_comb begin
        gx_d          = gx_q;
        gy_d          = gy_q;
        side1_d       = side1_q;
        side1_d.valid = bus.in_valid;
        if (bus.in_valid) begin
            gx_d           = grad_diff(gx_pos, gx_neg);
            gy_d           = grad_diff(gy_pos, gy_neg);
            side1_d.border = pos_border;
            side1_d.last   = pos_last;
        end
    end

    // Stage 2: absolute values.
    abs_t  ax_q, ax_d, ay_q, ay_d;
    side_t side2_q, side2_d;

    always_comb begin
        ax_d          = ax_q;
        ay_d          = ay_q;
        side2_d       = side2_q;
        side2_d.valid = side1_q.valid;
        if (side1_q.valid) begin
            ax_d           = grad_abs(gx_q);
            ay_d           = grad_abs(gy_q);
            side2_d.border = side1_q.border;
            side2_d.last   = side1_q.last;
        end
    end

    // Stage 3: saturated magnitude, border masking, threshold sampled here.
    mag_t   mag;
    pixel_t sat;
    pixel_t pix_q, pix_d;
    logic   edge_q, edge_d;
    side_t  side3_q, side3_d;

    assign mag = mag_t'(ax_q) + mag_t'(ay_q);
    assign sat = saturate(mag);

    always_comb begin
        pix_d         = pix_q;
        edge_d        = edge_q;
        side3_d       = side3_q;
        side3_d.valid = side2_q.valid;
        if (side2_q.valid) begin
            pix_d          = side2_q.border ? '0 : sat;
            edge_d         = !side2_q.border && (sat >= bus.threshold);
            side3_d.border = side2_q.border;
            side3_d.last   = side2_q.last;
        end
    end

    // NOTE: data registers are reset along with the valid bits so outputs read 0 out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gx_q    <= '0;
            gy_q    <= '0;
            side1_q <= '0;
            ax_q    <= '0;
            ay_q    <= '0;
            side2_q <= '0;
            pix_q   <= '0;
            edge_q  <= 1'b0;
            side3_q <= '0;
        end else begin
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            side1_q <= side1_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            side2_q <= side2_d;
            pix_q   <= pix_d;
            edge_q  <= edge_d;
            side3_q <= side3_d;
        end
    end

    assign bus.out_valid = side3_q.valid;
    assign bus.pix_out   = pix_q;
    assign bus.edge_flag = edge_q;
    assign bus.border    = side3_q.border;
    assign bus.last      = side3_q.last;

endmodule

// File: tb/tb_sobel_stage.sv
// Directed bench for sobel_stage on a 5x5 frame; expected tokens are queued at
// drive time from a bench-side model and compared when out_valid appears.
module tb_sobel_stage;
    import image_pkg::*;

    localparam int RW = 5;
    localparam int NR = 5;

    typedef struct {
        logic [7:0] pix;
        logic       border;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    sobel_stage_if bus ();

    sobel_stage #(
        .ROW_WIDTH (RW),
        .NUM_ROWS  (NR)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         row_m = 0;
    int         col_m = 0;
    int         out_cnt = 0;
    int         border_cnt = 0;
    int         last_cnt = 0;
    logic [2:0] vhist = 3'b000;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic window_t make_cols(input int a, input int b, input int c);
        window_t w;
        for (int r = 0; r < 3; r++) begin
            w[r][0] = pixel_t'(a);
            w[r][1] = pixel_t'(b);
            w[r][2] = pixel_t'(c);
        end
        return w;
    endfunction

    function automatic window_t make_rows(input int a, input int b, input int c);
        window_t w;
        for (int col = 0; col < 3; col++) begin
            w[0][col] = pixel_t'(a);
            w[1][col] = pixel_t'(b);
            w[2][col] = pixel_t'(c);
        end
        return w;
    endfunction

    function automatic int model_pix(input window_t w);
        int gx, gy, mag;
        gx = (int'(w[0][2]) + 2 * int'(w[1][2]) + int'(w[2][2]))
           - (int'(w[0][0]) + 2 * int'(w[1][0]) + int'(w[2][0]));
        gy = (int'(w[2][0]) + 2 * int'(w[2][1]) + int'(w[2][2]))
           - (int'(w[0][0]) + 2 * int'(w[0][1]) + int'(w[0][2]));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (mag > 255) ? 255 : mag;
    endfunction

    // Compare whatever the DUT presents at this falling edge against the scoreboard.
    task automatic sample();
        exp_t e;
        logic exp_edge;
        check("out_valid", 16'(bus.out_valid), 16'(vhist[2]));
        if (bus.out_valid === 1'b1) begin
            check("sb_nonempty", 16'(sb.size() != 0), 16'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                exp_edge = !e.border && (e.pix >= bus.threshold);
                check("pix_out", 16'(bus.pix_out), 16'(e.pix));
                check("border", 16'(bus.border), 16'(e.border));
                check("last", 16'(bus.last), 16'(e.last));
                check("edge", 16'(bus.edge_flag), 16'(exp_edge));
                out_cnt++;
                if (bus.border === 1'b1) border_cnt++;
                if (bus.last === 1'b1) last_cnt++;
            end
        end
    endtask

    task automatic step(input logic v, input window_t w);
        exp_t e;
        @(negedge clk);
        sample();
        vhist = {vhist[1:0], v};
        bus.in_valid = v;
        bus.window = w;
        if (v) begin
            e.border = (row_m < 2) || (col_m < 2);
            e.last = (row_m == NR - 1) && (col_m == RW - 1);
            e.pix = e.border ? 8'd0 : 8'(model_pix(w));
            sb.push_back(e);
            if (col_m == RW - 1) begin
                col_m = 0;
                row_m = (row_m == NR - 1) ? 0 : row_m + 1;
            end else begin
                col_m++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, make_cols(100, 100, 100));
    endtask

    window_t flat;
    logic    pattern [6];

    initial begin
        flat = make_cols(100, 100, 100);
        bus.in_valid = 1'b0;
        bus.window = flat;
        bus.threshold = 8'd128;

        // Reset state
        #2;
        check("reset_out_valid", 16'(bus.out_valid), 16'd0);
        check("reset_pix_out", 16'(bus.pix_out), 16'd0);
        check("reset_edge", 16'(bus.edge_flag), 16'd0);
        check("reset_border", 16'(bus.border), 16'd0);
        check("reset_last", 16'(bus.last), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Flat 5x5 frame
        for (int i = 0; i < RW * NR; i++) step(1'b1, flat);
        idle(4);
        check("frame_out_count", 16'(out_cnt), 16'd25);
        check("frame_border_count", 16'(border_cnt), 16'd16);
        check("frame_last_count", 16'(last_cnt), 16'd1);

        // Second frame: walk to (2,2) through border positions
        for (int i = 0; i < 12; i++) step(1'b1, flat);
        idle(4);
        bus.threshold = 8'd128;
        step(1'b1, make_cols(0, 0, 255));      // (2,2) Gx=1020 -> 255, edge
        idle(4);
        bus.threshold = 8'd40;
        step(1'b1, make_cols(10, 10, 20));     // (2,3) Gx=40, edge at threshold 40
        idle(4);
        bus.threshold = 8'd41;
        step(1'b1, make_cols(10, 10, 20));     // (2,4) Gx=40, no edge at 41
        idle(4);
        bus.threshold = 8'd128;
        step(1'b1, flat);                      // (3,0)
        step(1'b1, flat);                      // (3,1)
        step(1'b1, make_rows(200, 200, 0));    // (3,2) Gy=-800 -> 255
        idle(4);
        bus.threshold = 8'd0;
        step(1'b1, make_cols(50, 50, 50));     // (3,3) zero gradient, threshold 0 -> edge

        // Gapped input; out_valid must replay the pattern three cycles later
        bus.threshold = 8'd128;
        pattern = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) step(pattern[i], make_cols(0, 0, 200));
        idle(4);

        // Mid-frame asynchronous reset with tokens in flight
        for (int i = 0; i < 4; i++) step(1'b1, make_cols(0, 0, 255));
        @(posedge clk);
        #1;
        check("pre_reset_out_valid", 16'(bus.out_valid), 16'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_out_valid", 16'(bus.out_valid), 16'd0);
        check("async_reset_last", 16'(bus.last), 16'd0);
        bus.in_valid = 1'b0;
        sb.delete();
        row_m = 0;
        col_m = 0;
        vhist = 3'b000;
        @(negedge clk);
        reset_n = 1'b1;
        idle(4);
        step(1'b1, make_cols(0, 0, 255));      // treated as (0,0): border, pix 0
        idle(4);

        // Drain with a bounded wait
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        check("drain_empty", 16'(sb.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_stage.md
# sobel_stage

Downstream consumer of the 3x3 sliding-window line buffer. Each cycle it takes the current 8-bit pixel window, computes the Sobel gradient magnitude |Gx|+|Gy|, saturates it to 8 bits, and emits it through a 3-stage pipeline. Raster row/column counters mark border outputs and end-of-frame. The output feeds the threshold/display path of the edge-detection pipeline.

## Interface
- ROW_WIDTH, 640: pixels per row; must match the window stage.
- NUM_ROWS, 480: rows per frame.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  window was updated with a new pixel this cycle.
- window  in  8 x [3][3] unpacked  [r][c]; r=0 oldest row (top), c=0 oldest column (left); window[2][2] = newest pixel.
- threshold  in  8  edge threshold, sampled in stage 3.
- out_valid  out  1  pix_out/edge/border/last are valid.
- pix_out  out  8  saturated magnitude; 0 on border pixels.
- edge  out  1  pix_out >= threshold and not border.
- border  out  1  window did not hold a full 3x3 neighbourhood.
- last  out  1  output is the final pixel of the frame.

## Operation
- Raster position (row, col) of the newest pixel is tracked by counters advancing only on in_valid: col 0..ROW_WIDTH-1 wraps to 0 and increments row; row 0..NUM_ROWS-1 wraps to 0 after (NUM_ROWS-1, ROW_WIDTH-1). Counters reset to 0.
- Border = (row < 2) or (col < 2); evaluated in stage 1 from pre-increment counters.
- Stage 1: Gx = (w[0][2]+2w[1][2]+w[2][2]) - (w[0][0]+2w[1][0]+w[2][0]); Gy = (w[2][0]+2w[2][1]+w[2][2]) - (w[0][0]+2w[0][1]+w[0][2]). Sums of positive terms are 10-bit unsigned (max 1020); differences 11-bit signed (-1020..+1020). No overflow possible.
- Stage 2: absolute values, 10-bit unsigned each.
- Stage 3: mag = |Gx|+|Gy| as 11-bit (max 2040); pix_out = mag > 255 ? 255 : mag[7:0]; forced to 0 if border. edge = !border && pix_out >= threshold (threshold=0 makes every non-border pixel an edge).
- last = stage-3 token came from position (NUM_ROWS-1, ROW_WIDTH-1).
- Pipeline carries valid, border, last as sideband bits; data registers update only when their stage's incoming valid is 1 (hold otherwise).
- No backpressure: every in_valid produces exactly one out_valid; gaps in in_valid pass through as gaps.

## Timing
- Latency: in_valid at edge N -> out_valid at edge N+3. Full throughput, one pixel per cycle.
- Reset (asynchronous assert, synchronous release via clk): all valid bits, counters, pix_out, edge, border, last = 0. Reset mid-frame discards all in-flight tokens; the next in_valid is treated as (0,0).
- out_valid=0 cycles: pix_out/edge/border/last hold last value but carry no meaning; bench checks them only when out_valid=1.
- Frame wrap and a new in_valid on the same cycle: token gets (0,0) immediately; no idle cycle.
- threshold change takes effect on the token in stage 3 on that cycle.

## Structure
- Shared package (image_pkg): PIXEL_W=8, KERNEL_SIZE=3, pixel_t, window_t (3x3 pixel_t), grad_t (11-bit signed).
- One sub-module, raster_counter (row/col counters, border and last flags), parameterised by ROW_WIDTH/NUM_ROWS; reused by later stages.
- Gradient arithmetic inline in sobel_stage.

## Test plan
- Flat frame, all pixels 100, ROW_WIDTH=5, NUM_ROWS=5 -> 25 outputs, all pix_out=0, edge=0; border=1 for first 2 rows and first 2 columns (16 outputs), last=1 only on output 25.
- Non-border window columns 0,0,255 (vertical step) -> Gx=1020, Gy=0, pix_out=255, edge=1 with threshold=128.
- Window columns 10,10,20 -> Gx=40, pix_out=40; threshold=40 -> edge=1, threshold=41 -> edge=0.
- Window rows 200,200,0 -> Gy=-800, |Gy|=800, pix_out=255 (saturation of negative gradient).
- in_valid toggling 1,0,1,1,0,1 -> out_valid identical pattern delayed 3 cycles; counters advance 4 positions.
- reset_n pulsed low mid-frame with 2 tokens in flight -> out_valid=0 immediately (asynchronous), no stale outputs after release, next input reported at (0,0) with border=1.
